// File: rtl/fft_iter_ctrl_if.sv
// Handshake and memory-side bundle between the FFT sequencer and its
// consumers: data RAM, twiddle ROM and the 6-cycle complex butterfly.
interface fft_iter_ctrl_if #(
    parameter int LOG2N = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_strb;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output bf_strb, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  bf_strb, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_iter_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: one read+strobe every BF_PERIOD
// clocks per butterfly, write-back of the previous butterfly one clock later.
module fft_iter_ctrl #(
    parameter int LOG2N     = 8,
    parameter int BF_PERIOD = 6
) (
    input  logic            clk,
    input  logic            rst,
    fft_iter_ctrl_if.master bus
);
    localparam int               JW      = LOG2N - 1;
    localparam logic [JW-1:0]    J_LAST  = '1;
    localparam logic [2:0]       PH_LAST = 3'(BF_PERIOD - 1);
    localparam logic [LOG2N-1:0] S_LAST  = LOG2N'(LOG2N - 1);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, WB, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       phase, phase_nxt;
    logic [JW-1:0]    j, j_nxt;
    logic [LOG2N-1:0] s, s_nxt;
    logic             load_rd, load_prev, load_wr;

    logic [LOG2N-1:0] rd_a, rd_b, prev_a, prev_b, wr_a, wr_b;
    logic [JW-1:0]    rd_tw;
    logic [LOG2N-1:0] nxt_a, nxt_b, lo_mask, jx;
    logic [JW-1:0]    nxt_tw;

    // Next-state logic. Address registers are loaded only on entry to a
    // strobe cycle so that they stay put between reads; the write address
    // is a delayed copy of the previous read, never recomputed.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        j_nxt     = j;
        s_nxt     = s;
        load_rd   = 1'b0;
        load_prev = 1'b0;
        load_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    phase_nxt = 3'd0;
                    j_nxt     = '0;
                    s_nxt     = '0;
                    load_rd   = 1'b1;
                    load_prev = 1'b1;
                end
            end
            RUN: begin
                if (phase == PH_LAST) begin
                    phase_nxt = 3'd0;
                    load_prev = 1'b1;
                    if (j == J_LAST) begin
                        state_nxt = FLUSH;
                    end else begin
                        j_nxt   = j + 1'b1;
                        load_rd = 1'b1;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                    load_wr   = (phase == 3'd0) && (j != '0);
                end
            end
            FLUSH: begin
                state_nxt = WB;
                load_wr   = 1'b1;
            end
            WB: begin
                j_nxt     = '0;
                phase_nxt = 3'd0;
                if (s == S_LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                    s_nxt     = s + 1'b1;
                    load_rd   = 1'b1;
                    load_prev = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly j of stage s pairs addr_a with addr_a + 2^s: the group index
    // is shifted up one bit above the position-in-group field.
    always_comb begin
        lo_mask = (LOG2N'(1) << s_nxt) - LOG2N'(1);
        jx      = {1'b0, j_nxt};
        nxt_a   = ((jx & ~lo_mask) << 1) | (jx & lo_mask);
        nxt_b   = nxt_a | (LOG2N'(1) << s_nxt);
        nxt_tw  = JW'((jx & lo_mask) << (S_LAST - s_nxt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= 3'd0;
            j      <= '0;
            s      <= '0;
            rd_a   <= '0;
            rd_b   <= '0;
            rd_tw  <= '0;
            prev_a <= '0;
            prev_b <= '0;
            wr_a   <= '0;
            wr_b   <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            j     <= j_nxt;
            s     <= s_nxt;
            if (load_prev) begin
                prev_a <= rd_a;
                prev_b <= rd_b;
            end
            if (load_rd) begin
                rd_a  <= nxt_a;
                rd_b  <= nxt_b;
                rd_tw <= nxt_tw;
            end
            if (load_wr) begin
                wr_a <= prev_a;
                wr_b <= prev_b;
            end
        end
    end

    assign bus.busy      = (state == RUN) || (state == FLUSH) || (state == WB);
    assign bus.done      = (state == DONE);
    assign bus.stage     = s;
    assign bus.rd_en     = (state == RUN) && (phase == 3'd0);
    assign bus.bf_strb   = ((state == RUN) && (phase == 3'd0)) || (state == FLUSH);
    assign bus.wr_en     = ((state == RUN) && (phase == 3'd1) && (j != '0)) || (state == WB);
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_addr   = rd_tw;
    assign bus.wr_addr_a = wr_a;
    assign bus.wr_addr_b = wr_b;
endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Bench for fft_iter_ctrl at LOG2N=3: cycle-level reference model built from
// the stage/butterfly timing rules, plus a closed loop with RAM and butterfly.
module tb_fft_iter_ctrl;
    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;
    localparam int HALFN = N / 2;
    localparam int L     = 3 * N + 2;

    localparam int TA [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int TB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int TT [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    localparam int TW_RE [4] = '{16384, 11585, 0, -11585};
    localparam int TW_IM [4] = '{0, -11585, -16384, -11585};

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] stage;
        logic       rd_en;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [1:0] tw;
        logic       strb;
        logic       wr_en;
        logic [2:0] wa;
        logic [2:0] wb;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = -1;
    int   vectors = 0;
    int   miscompares = 0;

    bit    m_active = 1'b0;
    int    m_t0 = 0;
    outs_t m_held = '0;

    fft_iter_ctrl_if #(.LOG2N(LOG2N)) bus ();

    fft_iter_ctrl #(.LOG2N(LOG2N), .BF_PERIOD(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic outs_t observe();
        outs_t o;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.stage = bus.stage;
        o.rd_en = bus.rd_en;
        o.ra    = bus.rd_addr_a;
        o.rb    = bus.rd_addr_b;
        o.tw    = bus.tw_addr;
        o.strb  = bus.bf_strb;
        o.wr_en = bus.wr_en;
        o.wa    = bus.wr_addr_a;
        o.wb    = bus.wr_addr_b;
        return o;
    endfunction

    function automatic void addr_of(input int s, input int j, output int a, output int b, output int t);
        int half = 1 << s;
        int g    = j / half;
        int p    = j % half;
        a = g * 2 * half + p;
        b = a + half;
        t = p * (N / (2 * half));
    endfunction

    // Expected outputs for cycle c, from the transform start time alone.
    function automatic outs_t model_expect(input int c);
        outs_t e = m_held;
        int o, s, r, k, ph, a, b, t;
        e.busy = 0; e.done = 0; e.rd_en = 0; e.strb = 0; e.wr_en = 0;
        if (m_active) begin
            o = c - m_t0;
            if (o == LOG2N * L) begin
                e.done  = 1;
                e.stage = 3'(LOG2N - 1);
            end else if (o >= 0 && o < LOG2N * L) begin
                s = o / L;
                r = o % L;
                e.busy  = 1;
                e.stage = 3'(s);
                if (r < 3 * N) begin
                    k  = r / 6;
                    ph = r % 6;
                    if (ph == 0) begin
                        addr_of(s, k, a, b, t);
                        e.rd_en = 1; e.strb = 1;
                        e.ra = 3'(a); e.rb = 3'(b); e.tw = 2'(t);
                    end
                    if (ph == 1 && k >= 1) begin
                        addr_of(s, k - 1, a, b, t);
                        e.wr_en = 1; e.wa = 3'(a); e.wb = 3'(b);
                    end
                end else if (r == 3 * N) begin
                    e.strb = 1;
                end else begin
                    addr_of(s, HALFN - 1, a, b, t);
                    e.wr_en = 1; e.wa = 3'(a); e.wb = 3'(b);
                end
            end
        end
        return e;
    endfunction

    function automatic void model_commit(input int c, input outs_t e, input bit st, input bit rs);
        m_held = e;
        if (rs) begin
            m_active = 0;
            m_held   = '0;
        end else begin
            if (m_active && (c - m_t0) >= LOG2N * L) m_active = 0;
            if (st && !e.busy && !e.done) begin
                m_active = 1;
                m_t0     = c + 1;
            end
        end
    endfunction

    task automatic drive(input bit st, input bit rs);
        @(posedge clk);
        cyc++;
        #1;
        bus.start = st;
        rst       = rs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        outs_t e, o;
        bit st, rs;
        for (int i = 0; i < 115; i++) begin
            rs = (i < 3) || (i == 25) || (i == 26);
            st = (i == 4) || (i == 30);
            drive(st, rs);
            e = model_expect(cyc); o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL reset cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (i == 26 || i == 27) begin
                vectors++;
                if (o !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_zero cyc=%0d got=%h exp=0", cyc, o);
                end
            end
            model_commit(cyc, e, st, rs);
        end
    endtask

    task automatic test_timing();
        outs_t e, o;
        bit st;
        int ts = -1, first_strb = -1, done_cyc = -1, busy_n = 0, strb_n = 0;
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            st = (i == 3);
            drive(st, 0);
            e = model_expect(cyc); o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL timing cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            model_commit(cyc, e, st, 0);
            if (st) ts = cyc;
            if (ts >= 0) begin
                if (o.busy) busy_n++;
                if (o.strb) begin
                    strb_n++;
                    if (first_strb < 0) first_strb = cyc;
                end
                if (o.done) done_cyc = cyc;
            end
        end
        vectors++;
        if (done_cyc != ts + 1 + LOG2N * L) begin
            miscompares++;
            $display("[TB] FAIL done_latency got=%0d exp=%0d", done_cyc - ts, 1 + LOG2N * L);
        end
        vectors++;
        if (first_strb != ts + 1) begin
            miscompares++;
            $display("[TB] FAIL first_strobe got=%0d exp=%0d", first_strb - ts, 1);
        end
        vectors++;
        if (busy_n != LOG2N * L) begin
            miscompares++;
            $display("[TB] FAIL busy_cycles got=%0d exp=%0d", busy_n, LOG2N * L);
        end
        vectors++;
        if (strb_n != LOG2N * (HALFN + 1)) begin
            miscompares++;
            $display("[TB] FAIL strobe_count got=%0d exp=%0d", strb_n, LOG2N * (HALFN + 1));
        end
    endtask

    task automatic test_address_table();
        outs_t e, o;
        bit st;
        int qa[$], qb[$], qt[$], wa[$], wb[$];
        bit fin = 0;
        for (int i = 0; i < 200 && !fin; i++) begin
            st = (i == 1);
            drive(st, 0);
            e = model_expect(cyc); o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL addr_cycle cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            model_commit(cyc, e, st, 0);
            if (o.rd_en) begin qa.push_back(int'(o.ra)); qb.push_back(int'(o.rb)); qt.push_back(int'(o.tw)); end
            if (o.wr_en) begin wa.push_back(int'(o.wa)); wb.push_back(int'(o.wb)); end
            if (o.done) fin = 1;
        end
        vectors++;
        if (qa.size() != 12 || wa.size() != 12) begin
            miscompares++;
            $display("[TB] FAIL addr_count reads=%0d writes=%0d exp=12", qa.size(), wa.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                vectors++;
                if (qa[i] != TA[i] || qb[i] != TB[i] || qt[i] != TT[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rd_pair[%0d] got=(%0d,%0d)t%0d exp=(%0d,%0d)t%0d",
                             i, qa[i], qb[i], qt[i], TA[i], TB[i], TT[i]);
                end
                vectors++;
                if (wa[i] != TA[i] || wb[i] != TB[i]) begin
                    miscompares++;
                    $display("[TB] FAIL wr_pair[%0d] got=(%0d,%0d) exp=(%0d,%0d)",
                             i, wa[i], wb[i], TA[i], TB[i]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        outs_t e, o, p;
        bit st;
        int phase = 0, ts1 = -1, ts2 = -1, d1 = -1, d2 = -1, done_n = 0;
        for (int i = 0; i < 260 && d2 < 0; i++) begin
            p  = model_expect(cyc + 1);
            st = 0;
            if (phase == 0 && i == 2) begin st = 1; ts1 = cyc + 1; phase = 1; end
            else if (p.busy) st = ($urandom_range(0, 4) == 0);
            else if (p.done) st = 1;
            else if (phase == 2) begin st = 1; ts2 = cyc + 1; phase = 3; end
            drive(st, 0);
            e = model_expect(cyc); o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL start_ignored cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            model_commit(cyc, e, st, 0);
            if (o.done) begin
                done_n++;
                if (phase == 1) begin d1 = cyc; phase = 2; end
                else if (phase == 3) d2 = cyc;
            end
        end
        vectors++;
        if (d1 - ts1 != 1 + LOG2N * L || d2 - ts2 != 1 + LOG2N * L || done_n != 2) begin
            miscompares++;
            $display("[TB] FAIL restart_timing got=%0d/%0d dones=%0d exp=%0d/%0d dones=2",
                     d1 - ts1, d2 - ts2, done_n, 1 + LOG2N * L, 1 + LOG2N * L);
        end
    endtask

    task automatic test_closed_loop();
        outs_t e, o;
        bit st;
        int ram_re[N], ram_im[N], wst[N];
        int rd_ar = 0, rd_ai = 0, rd_br = 0, rd_bi = 0, rd_t = 0;
        int bo_ar = 0, bo_ai = 0, bo_br = 0, bo_bi = 0, tr, ti;
        bit fin = 0;
        for (int i = 0; i < N; i++) begin
            ram_re[i] = (i == 0) ? 32'h4000 : 0;
            ram_im[i] = 0;
            wst[i]    = -1;
        end
        for (int i = 0; i < 200 && !fin; i++) begin
            st = (i == 2);
            drive(st, 0);
            e = model_expect(cyc); o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL loop_cycle cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            model_commit(cyc, e, st, 0);
            if (o.strb) begin
                tr = (rd_br * TW_RE[rd_t] - rd_bi * TW_IM[rd_t]) >>> 14;
                ti = (rd_br * TW_IM[rd_t] + rd_bi * TW_RE[rd_t]) >>> 14;
                bo_ar = (rd_ar + tr + 1) >>> 1;
                bo_ai = (rd_ai + ti + 1) >>> 1;
                bo_br = (rd_ar - tr + 1) >>> 1;
                bo_bi = (rd_ai - ti + 1) >>> 1;
            end
            if (o.wr_en) begin
                ram_re[o.wa] = bo_ar; ram_im[o.wa] = bo_ai;
                ram_re[o.wb] = bo_br; ram_im[o.wb] = bo_bi;
                wst[o.wa] = int'(e.stage);
                wst[o.wb] = int'(e.stage);
            end
            if (o.rd_en) begin
                vectors++;
                if (wst[o.ra] != int'(e.stage) - 1 || wst[o.rb] != int'(e.stage) - 1) begin
                    miscompares++;
                    $display("[TB] FAIL hazard cyc=%0d stage=%0d written_in=%0d/%0d exp=%0d",
                             cyc, e.stage, wst[o.ra], wst[o.rb], int'(e.stage) - 1);
                end
                rd_ar = ram_re[o.ra]; rd_ai = ram_im[o.ra];
                rd_br = ram_re[o.rb]; rd_bi = ram_im[o.rb];
                rd_t  = int'(o.tw);
            end
            if (o.done) fin = 1;
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("[TB] FAIL loop_timeout got=no_done exp=done");
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (ram_re[i] < 32'h07FF || ram_re[i] > 32'h0801 || ram_im[i] < -1 || ram_im[i] > 1) begin
                miscompares++;
                $display("[TB] FAIL impulse_out[%0d] got=%0h+j%0d exp=800+j0", i, ram_re[i], ram_im[i]);
            end
        end
    endtask

    task automatic test_random();
        outs_t e, o;
        bit st, rs;
        for (int i = 0; i < 1600; i++) begin
            st = (i < 1500) && ($urandom_range(0, 19) == 0);
            rs = (i < 1500) && ($urandom_range(0, 299) == 0);
            drive(st, rs);
            e = model_expect(cyc); o = observe(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            model_commit(cyc, e, st, rs);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        $display("[TB] fft_iter_ctrl bench, LOG2N=%0d", LOG2N);
        test_reset();
        test_timing();
        test_address_table();
        test_start_ignored();
        test_closed_loop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
